// File: rtl/tx_pkg.sv
// Shared state encoding and frame constants for the tx_ctrl transmit controller.
// Build option TX_PARITY_EN (see tx_ctrl) selects a parity bit over a second stop bit.
package tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } tx_state_e;

    localparam int FRAME_W = 11;
    localparam int NBITS   = 11;

    localparam logic [FRAME_W-1:0] IDLE_FRAME = 11'h7FF;

endpackage

// File: rtl/tx_baud_gen.sv
// tx_baud_gen: bit-time counter for tx_ctrl; tick flags the last clock of each bit time.
module tx_baud_gen #(
    parameter int DIV_W = 19
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [DIV_W-1:0] k,
    output logic             tick
);

    logic [DIV_W-1:0] k_eff;
    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign k_eff = (k < DIV_W'(2)) ? DIV_W'(2) : k;

    // Compared against the live divisor, so a smaller k ends the current bit early.
    assign tick = (cnt_q >= k_eff - DIV_W'(1));

    always_comb begin
        cnt_d = cnt_q + DIV_W'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tx_ctrl.sv
// tx_ctrl: one-byte holding register and IDLE/LOAD/SHIFT sequencer driving an external 11-bit shifter.
// Build option TX_PARITY_EN: frame bit 9 carries parity; without it that bit is a second stop bit.
module tx_ctrl
    import tx_pkg::*;
#(
    parameter int DIV_W = 19
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DIV_W-1:0]   k,
    input  logic               parity_odd,
    input  logic [7:0]         data,
    input  logic               write,
    output logic               txrdy,
    output logic               busy,
    output logic [FRAME_W-1:0] frame,
    output logic               ld,
    output logic               sh,
    output logic               done,
    output logic               ovr
);

    tx_state_e          state_q, state_d;
    logic [7:0]         hold_q, hold_d;
    logic               txrdy_q, txrdy_d;
    logic               busy_q, busy_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               ld_q, ld_d;
    logic               sh_q, sh_d;
    logic               done_q, done_d;
    logic               ovr_q, ovr_d;
    logic [3:0]         bit_q, bit_d;
    logic               tick;
    logic               clr;
    logic               par_bit;

`ifdef TX_PARITY_EN
    assign par_bit = (^hold_q) ^ parity_odd;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
    assign par_bit           = 1'b1;
`endif

    tx_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .k     (k),
        .tick  (tick)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        txrdy_d = txrdy_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        ld_d    = 1'b0;
        sh_d    = 1'b0;
        done_d  = 1'b0;
        ovr_d   = 1'b0;

        if (write) begin
            if (txrdy_q) begin
                hold_d  = data;
                txrdy_d = 1'b0;
            end else begin
                ovr_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (!txrdy_q) state_d = LOAD;
            end
            LOAD: begin
                txrdy_d = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                // The cycle showing done decides what follows, keeping ld clear of the last sh.
                if (done_q) begin
                    state_d = txrdy_q ? IDLE : LOAD;
                end else if (tick) begin
                    sh_d   = 1'b1;
                    bit_d  = bit_q + 4'd1;
                    done_d = (bit_q == 4'(NBITS - 1));
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != SHIFT) bit_d = '0;

        if (state_d == LOAD) begin
            ld_d    = 1'b1;
            frame_d = {1'b1, par_bit, hold_q, 1'b0};
        end

        busy_d = (state_d != IDLE);
        clr    = (state_d != SHIFT);
    end

    // NOTE: non-blocking assignments so every flop samples values from before the edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            txrdy_q <= 1'b1;
            busy_q  <= 1'b0;
            frame_q <= IDLE_FRAME;
            ld_q    <= 1'b0;
            sh_q    <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            txrdy_q <= txrdy_d;
            busy_q  <= busy_d;
            frame_q <= frame_d;
            ld_q    <= ld_d;
            sh_q    <= sh_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            bit_q   <= bit_d;
        end
    end

    // NOTE: the held byte needs no reset; txrdy_q alone says whether it holds anything.
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

    assign txrdy = txrdy_q;
    assign busy  = busy_q;
    assign frame = frame_q;
    assign ld    = ld_q;
    assign sh    = sh_q;
    assign done  = done_q;
    assign ovr   = ovr_q;

endmodule

// File: tb/tb_tx_ctrl.sv
// Scoreboard bench for tx_ctrl: writes push predicted strobes/frames; a negedge monitor pops and compares.
module tb_tx_ctrl;

    localparam int DIV_W = 19;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [DIV_W-1:0] k = DIV_W'(4);
    logic             parity_odd = 1'b0;
    logic [7:0]       data = 8'h00;
    logic             write = 1'b0;
    logic             txrdy, busy, ld, sh, done, ovr;
    logic [10:0]      frame;

    tx_ctrl #(.DIV_W(DIV_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .k          (k),
        .parity_odd (parity_odd),
        .data       (data),
        .write      (write),
        .txrdy      (txrdy),
        .busy       (busy),
        .frame      (frame),
        .ld         (ld),
        .sh         (sh),
        .done       (done),
        .ovr        (ovr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [10:0] frame;
    } load_ev_t;

    load_ev_t exp_ld[$];
    load_ev_t frames[$];
    int       exp_sh[$];
    int       exp_done[$];
    int       exp_ovr[$];
    int       last_w, last_l;
    bit       have_last = 1'b0;
    int       bit_time = 4;
    int       n_vec = 0;
    int       n_fail = 0;
    bit       mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [10:0] ref_frame(input logic [7:0] d, input logic odd);
        logic p;
`ifdef TX_PARITY_EN
        p = (^d) ^ odd;
`else
        p = odd | 1'b1;
`endif
        return {1'b1, p, d, 1'b0};
    endfunction

    function automatic logic exp_txrdy(input int c);
        return !(have_last && last_w < c && c <= last_l);
    endfunction

    function automatic logic exp_busy(input int c);
        logic b = 1'b0;
        foreach (frames[i])
            if (frames[i].at <= c && c <= frames[i].at + 11 * bit_time) b = 1'b1;
        return b;
    endfunction

    function automatic logic [10:0] exp_frame(input int c);
        logic [10:0] f = 11'h7FF;
        foreach (frames[i])
            if (frames[i].at <= c) f = frames[i].frame;
        return f;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_model();
        exp_ld.delete();
        frames.delete();
        exp_sh.delete();
        exp_done.delete();
        exp_ovr.delete();
        have_last = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
        flush_model();
    endtask

    task automatic set_k(input int kv);
        k        = DIV_W'(kv);
        bit_time = (kv < 2) ? 2 : kv;
    endtask

    task automatic issue_write(input logic [7:0] d);
        int       l;
        load_ev_t ev;
        if (exp_txrdy(cyc)) begin
            l = cyc + 2;
            if (have_last && last_l + 11 * bit_time + 1 > l) l = last_l + 11 * bit_time + 1;
            ev.at    = l;
            ev.frame = ref_frame(d, parity_odd);
            exp_ld.push_back(ev);
            frames.push_back(ev);
            for (int j = 1; j <= 11; j++) exp_sh.push_back(l + j * bit_time);
            exp_done.push_back(l + 11 * bit_time);
            have_last = 1'b1;
            last_w    = cyc;
            last_l    = l;
        end else begin
            exp_ovr.push_back(cyc + 1);
        end
        write = 1'b1;
        data  = d;
        step();
        write = 1'b0;
        data  = 8'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_ld.size() + exp_sh.size() + exp_done.size() + exp_ovr.size()) != 0 && n < 3000) begin
            step();
            n++;
        end
        check("drain_pending", exp_ld.size() + exp_sh.size() + exp_done.size() + exp_ovr.size(), 0);
        repeat (3) step();
    endtask

    task automatic wait_txrdy();
        int n = 0;
        while (!txrdy && n < 200) begin
            step();
            n++;
        end
        check("txrdy_timeout", (n < 200) ? 1 : 0, 1);
    endtask

    always @(negedge clk) begin
        logic     e;
        load_ev_t f;
        if (mon_en) begin
            check("txrdy", txrdy, exp_txrdy(cyc));
            check("busy", busy, exp_busy(cyc));
            check("frame_hold", frame, exp_frame(cyc));
            check("ld_sh_overlap", ld & sh, 0);

            e = exp_ld.size() != 0 && exp_ld[0].at == cyc;
            check("ld", ld, e);
            if (e) begin
                f = exp_ld.pop_front();
                check("ld_frame", frame, f.frame);
            end

            e = exp_sh.size() != 0 && exp_sh[0] == cyc;
            check("sh", sh, e);
            if (e) void'(exp_sh.pop_front());

            e = exp_done.size() != 0 && exp_done[0] == cyc;
            check("done", done, e);
            if (e) void'(exp_done.pop_front());

            e = exp_ovr.size() != 0 && exp_ovr[0] == cyc;
            check("ovr", ovr, e);
            if (e) void'(exp_ovr.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish @cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int target;
        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        flush_model();
        mon_en = 1'b1;
        step();

        // Single frames, even then odd parity, k = 4.
        set_k(4);
        parity_odd = 1'b0;
        issue_write(8'h55);
        drain();
        parity_odd = 1'b1;
        issue_write(8'h55);
        drain();

        // Second byte written as soon as the holding register empties: back-to-back frames.
        parity_odd = 1'b0;
        issue_write(8'h55);
        wait_txrdy();
        issue_write(8'hA3);
        drain();

        // Writes on consecutive cycles: the second is dropped with an overrun pulse.
        issue_write(8'h3C);
        issue_write(8'hC3);
        drain();

        // Reset during the fifth shift strobe, then a fresh frame.
        issue_write(8'h96);
        target = last_l + 5 * bit_time;
        while (cyc < target) step();
        apply_reset();
        step();
        issue_write(8'h5A);
        drain();

        // Divisors below 2 behave as 2.
        for (int kv = 0; kv < 2; kv++) begin
            apply_reset();
            set_k(kv);
            step();
            issue_write(8'($urandom));
            issue_write(8'($urandom));
            wait_txrdy();
            issue_write(8'($urandom));
            drain();
        end

        // Random traffic per epoch; each epoch ends with an unsynchronised reset.
        for (int ep = 0; ep < 6; ep++) begin
            apply_reset();
            set_k(int'($urandom_range(0, 6)));
            parity_odd = 1'($urandom_range(0, 1));
            step();
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 9) == 0) issue_write(8'($urandom));
                else step();
            end
        end
        apply_reset();
        set_k(3);
        step();
        issue_write(8'hE7);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
